// File: rtl/axi_pkg.sv
// Shared AXI constants: burst types and response codes.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // AXI size encoding for a beat of the given byte width
    function automatic logic [2:0] axi_size(input int unsigned bytes);
        return 3'($clog2(bytes));
    endfunction

endpackage

// File: rtl/axi_ifc.sv
// AXI4 bus bundle with master and slave views.
interface axi_ifc #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_burst_master.sv
// Single-command AXI4 INCR burst master: one write or read burst per command,
// with a one-cycle done pulse and an error flag qualified by done.
module axi_burst_master
    import axi_pkg::*;
#(
    parameter int unsigned ID      = 0,
    parameter int unsigned IDWIDTH = 4,
    parameter int unsigned AWIDTH  = 32,
    parameter int unsigned DWIDTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    input  logic              rd_ready,
    output logic              done,
    output logic              err,
    axi_ifc.master            m
);

    localparam int unsigned STRBW  = DWIDTH / 8;
    localparam logic [2:0]  AXSIZE = axi_size(STRBW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WDATA,
        S_WRESP,
        S_RADDR,
        S_RDATA
    } state_e;

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_acc_q, err_acc_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              wlast_c;
    logic              beat_err_c;

    // Address/control fields are constant for the whole burst
    assign m.awid    = IDWIDTH'(ID);
    assign m.awaddr  = addr_q;
    assign m.awlen   = len_q;
    assign m.awsize  = AXSIZE;
    assign m.awburst = AXI_BURST_INCR;
    assign m.arid    = IDWIDTH'(ID);
    assign m.araddr  = addr_q;
    assign m.arlen   = len_q;
    assign m.arsize  = AXSIZE;
    assign m.arburst = AXI_BURST_INCR;
    assign m.wdata   = wr_data;
    assign m.wstrb   = '1;

    assign wlast_c   = (state_q == S_WDATA) && (cnt_q == len_q);
    assign m.wlast   = wlast_c;

    assign done      = done_q;
    assign err       = err_q;

    // State and datapath registers; reset wins over any handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            err_acc_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            err_acc_q <= err_acc_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state, beat counting, error accumulation and handshake steering
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        err_acc_d  = err_acc_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        beat_err_c = 1'b0;
        cmd_ready  = 1'b0;
        wr_ready   = 1'b0;
        rd_valid   = 1'b0;
        rd_last    = 1'b0;
        rd_data    = '0;
        m.awvalid  = 1'b0;
        m.wvalid   = 1'b0;
        m.bready   = 1'b0;
        m.arvalid  = 1'b0;
        m.rready   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d    = cmd_addr & ~AWIDTH'(3);
                    len_d     = cmd_len;
                    cnt_d     = '0;
                    err_acc_d = 1'b0;
                    state_d   = cmd_write ? S_WADDR : S_RADDR;
                end
            end
            S_WADDR: begin
                m.awvalid = 1'b1;
                if (m.awready) begin
                    state_d = S_WDATA;
                end
            end
            S_WDATA: begin
                m.wvalid = wr_valid;
                wr_ready = m.wready;
                if (wr_valid && m.wready) begin
                    cnt_d = cnt_q + 8'd1;
                    if (wlast_c) begin
                        state_d = S_WRESP;
                    end
                end
            end
            S_WRESP: begin
                m.bready = 1'b1;
                if (m.bvalid) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = err_acc_q | (m.bresp != AXI_RESP_OKAY);
                end
            end
            S_RADDR: begin
                m.arvalid = 1'b1;
                if (m.arready) begin
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                rd_valid = m.rvalid;
                rd_data  = m.rdata;
                rd_last  = m.rlast;
                m.rready = rd_ready;
                if (m.rvalid && rd_ready) begin
                    cnt_d      = cnt_q + 8'd1;
                    // Flag a bad response, an early rlast or a missing rlast
                    beat_err_c = (m.rresp != AXI_RESP_OKAY) || (m.rlast != (cnt_q == len_q));
                    if (m.rlast) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        err_d   = err_acc_q | beat_err_c;
                    end else begin
                        err_acc_d = err_acc_q | beat_err_c;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: SRAM-style AXI slave model, table of burst
// commands, read-data scoreboard and hand-written reset-mid-burst sequence.
module tb_axi_burst_master;
    import axi_pkg::*;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned IW    = 4;
    localparam int unsigned TB_ID = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [7:0]    cmd_len = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_last;
    logic          rd_ready = 1'b1;
    logic          done;
    logic          err;

    axi_ifc #(.ID_W(IW), .ADDR_W(AW), .DATA_W(DW)) bus ();

    axi_burst_master #(
        .ID(TB_ID), .IDWIDTH(IW), .AWIDTH(AW), .DWIDTH(DW)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
        .done(done), .err(err),
        .m(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- slave model configuration ----------------
    int          delay_cfg = 0;
    logic        gaps_cfg  = 1'b0;
    logic [1:0]  bresp_cfg = AXI_RESP_OKAY;
    int          early_cfg = -1;
    logic [31:0] exp_a = '0;
    logic [7:0]  exp_l = '0;

    logic [31:0] mem [0:1023];
    logic        w_phase, b_phase, r_phase;
    logic [31:0] w_ptr, r_ptr;
    logic [7:0]  w_len, w_beat, r_len, r_beat;
    int          aw_wait, ar_wait;
    logic        wready_en, rvalid_en;
    logic        aw_pend, ar_pend;
    logic [31:0] aw_hold, ar_hold;

    assign bus.awready = bus.awvalid && !w_phase && !b_phase && (aw_wait >= delay_cfg);
    assign bus.wready  = w_phase && wready_en;
    assign bus.bvalid  = b_phase;
    assign bus.bresp   = bresp_cfg;
    assign bus.bid     = IW'(TB_ID);
    assign bus.arready = bus.arvalid && !r_phase && (ar_wait >= delay_cfg);
    assign bus.rvalid  = r_phase && rvalid_en;
    assign bus.rdata   = mem[r_ptr[11:2]];
    assign bus.rresp   = AXI_RESP_OKAY;
    assign bus.rid     = IW'(TB_ID);
    assign bus.rlast   = r_phase && ((r_beat == r_len) || (early_cfg >= 0 && int'(r_beat) == early_cfg));

    // SRAM slave: delayed address ready, random ready/valid gaps, protocol checks
    always @(posedge clk) begin
        if (reset) begin
            w_phase   <= 1'b0;
            b_phase   <= 1'b0;
            r_phase   <= 1'b0;
            w_beat    <= '0;
            r_beat    <= '0;
            aw_wait   <= 0;
            ar_wait   <= 0;
            aw_pend   <= 1'b0;
            ar_pend   <= 1'b0;
            wready_en <= 1'b1;
            rvalid_en <= 1'b1;
        end else begin
            if (aw_pend && bus.awvalid) check("awaddr_stable", 64'(bus.awaddr), 64'(aw_hold));
            if (ar_pend && bus.arvalid) check("araddr_stable", 64'(bus.araddr), 64'(ar_hold));
            aw_pend <= bus.awvalid && !bus.awready;
            ar_pend <= bus.arvalid && !bus.arready;
            aw_hold <= bus.awaddr;
            ar_hold <= bus.araddr;
            aw_wait <= (bus.awvalid && !bus.awready) ? aw_wait + 1 : 0;
            ar_wait <= (bus.arvalid && !bus.arready) ? ar_wait + 1 : 0;

            if (bus.awvalid && bus.awready) begin
                check("aw_fields",
                      64'({bus.awid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst}),
                      64'({IW'(TB_ID), exp_a, exp_l, 3'd2, 2'b01}));
                w_phase <= 1'b1;
                w_ptr   <= bus.awaddr;
                w_len   <= bus.awlen;
                w_beat  <= '0;
            end
            if (bus.wvalid && bus.wready) begin
                check("wlast_wstrb", 64'({bus.wlast, bus.wstrb}), 64'({w_beat == w_len, 4'hF}));
                mem[w_ptr[11:2]] <= bus.wdata;
                w_ptr  <= w_ptr + 32'd4;
                w_beat <= w_beat + 8'd1;
                if (bus.wlast) begin
                    w_phase <= 1'b0;
                    b_phase <= 1'b1;
                end
            end
            if (bus.bvalid && bus.bready) b_phase <= 1'b0;

            if (bus.arvalid && bus.arready) begin
                check("ar_fields",
                      64'({bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst}),
                      64'({IW'(TB_ID), exp_a, exp_l, 3'd2, 2'b01}));
                r_phase <= 1'b1;
                r_ptr   <= bus.araddr;
                r_len   <= bus.arlen;
                r_beat  <= '0;
            end
            if (bus.rvalid && bus.rready) begin
                r_ptr  <= r_ptr + 32'd4;
                r_beat <= r_beat + 8'd1;
                if (bus.rlast) r_phase <= 1'b0;
            end

            wready_en <= gaps_cfg ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!bus.rvalid || bus.rready) rvalid_en <= gaps_cfg ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- read scoreboard ----------------
    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } rexp_t;

    rexp_t exp_q[$];
    rexp_t rexp;

    // Compare every accepted read beat against the queued expectation
    always @(negedge clk) begin
        if (!reset && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_unexpected: got beat 0x%0h, expected none", rd_data);
            end else begin
                rexp = exp_q.pop_front();
                check("rd_beat", 64'({rd_data, rd_last}), 64'({rexp.data, rexp.last}));
            end
        end
    end

    // Count done pulses
    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    // ---------------- command table ----------------
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [31:0] seed;
        logic        gaps;
        int          delay;
        logic [1:0]  bresp;
        int          early;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 10;
    vec_t        vecs[NVEC];
    logic [31:0] model [0:1023];

    task automatic run_vec(input vec_t v);
        logic [31:0] base;
        int          beat;
        int          cyc;
        int          nrd;
        logic        hs;
        logic        got;
        base      = v.addr & ~32'd3;
        delay_cfg = v.delay;
        gaps_cfg  = v.gaps;
        bresp_cfg = v.bresp;
        early_cfg = v.early;
        exp_a     = base;
        exp_l     = v.len;
        if (v.wr) begin
            for (int i = 0; i <= int'(v.len); i++) model[int'(base[11:2]) + i] = v.seed + 32'(i);
        end else begin
            nrd = (v.early >= 0) ? v.early + 1 : int'(v.len) + 1;
            for (int i = 0; i < nrd; i++) exp_q.push_back('{model[int'(base[11:2]) + i], i == nrd - 1});
        end

        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        @(negedge clk);
        check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;

        beat = 0;
        cyc  = 0;
        got  = 1'b0;
        while (!got && cyc < 3000) begin
            wr_valid = v.wr && (beat <= int'(v.len)) && (!v.gaps || $urandom_range(0, 3) != 0);
            wr_data  = v.seed + 32'(beat);
            rd_ready = !v.gaps || $urandom_range(0, 2) != 0;
            @(negedge clk);
            hs  = wr_valid && wr_ready;
            got = done;
            if (!got) begin
                @(posedge clk);
                if (hs) beat++;
                #1;
            end
            cyc++;
        end

        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", cyc);
        end else begin
            check("done_err_ready", 64'({cmd_ready, err}), 64'({1'b1, v.exp_err}));
            @(negedge clk);
            check("done_single_pulse", 64'({done, err}), 64'(0));
        end
        wr_valid = 1'b0;
        rd_ready = 1'b1;

        if (v.wr) begin
            for (int i = 0; i <= int'(v.len); i++)
                check("mem_word", 64'(mem[int'(base[11:2]) + i]), 64'(v.seed + 32'(i)));
        end else begin
            check("rd_drained", 64'(exp_q.size()), 64'(0));
            exp_q.delete();
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int beat;
        int cyc;

        // wr, addr, len, seed, gaps, delay, bresp, early, exp_err
        vecs[0] = '{1'b1, 32'h100, 8'd3,  32'd1,        1'b0, 0, AXI_RESP_OKAY,   -1, 1'b0};
        vecs[1] = '{1'b0, 32'h100, 8'd3,  32'd0,        1'b0, 0, AXI_RESP_OKAY,   -1, 1'b0};
        vecs[2] = '{1'b1, 32'h040, 8'd0,  32'hDEADBEEF, 1'b0, 0, AXI_RESP_OKAY,   -1, 1'b0};
        vecs[3] = '{1'b0, 32'h040, 8'd0,  32'd0,        1'b0, 0, AXI_RESP_OKAY,   -1, 1'b0};
        vecs[4] = '{1'b1, 32'h200, 8'd15, 32'hA5A50000, 1'b1, 5, AXI_RESP_OKAY,   -1, 1'b0};
        vecs[5] = '{1'b0, 32'h200, 8'd15, 32'd0,        1'b1, 5, AXI_RESP_OKAY,   -1, 1'b0};
        vecs[6] = '{1'b1, 32'h080, 8'd1,  32'h000000A0, 1'b0, 0, AXI_RESP_SLVERR, -1, 1'b1};
        vecs[7] = '{1'b0, 32'h100, 8'd3,  32'd0,        1'b0, 0, AXI_RESP_OKAY,    1, 1'b1};
        vecs[8] = '{1'b1, 32'h2C3, 8'd1,  32'h00000077, 1'b0, 2, AXI_RESP_OKAY,   -1, 1'b0};
        vecs[9] = '{1'b0, 32'h2C1, 8'd1,  32'd0,        1'b1, 0, AXI_RESP_OKAY,   -1, 1'b0};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              64'({cmd_ready, done, err, wr_ready, rd_valid, rd_last,
                   bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}),
              64'(11'b100_0000_0000));
        @(posedge clk); #1;
        reset = 1'b0;

        for (int k = 0; k < NVEC; k++) run_vec(vecs[k]);

        // Reset while the third write beat is pending
        delay_cfg = 0;
        gaps_cfg  = 1'b0;
        bresp_cfg = AXI_RESP_OKAY;
        early_cfg = -1;
        exp_a     = 32'h300;
        exp_l     = 8'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h300;
        cmd_len   = 8'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wr_valid  = 1'b1;
        wr_data   = 32'h55;
        beat = 0;
        cyc  = 0;
        while (beat < 2 && cyc < 100) begin
            @(negedge clk);
            if (wr_valid && wr_ready) beat++;
            @(posedge clk); #1;
            wr_data = 32'h55 + 32'(beat);
            cyc++;
        end
        if (beat < 2) begin
            n_checks++;
            n_fail++;
            $display("FAIL reset_seq_timeout: got %0d beats, expected 2", beat);
        end
        reset = 1'b1;
        @(negedge clk);
        check("in_wdata_before_reset", 64'({bus.wvalid, wr_ready, cmd_ready}), 64'(3'b110));
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_mid_burst",
              64'({cmd_ready, done, err, wr_ready, rd_valid, rd_last,
                   bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}),
              64'(11'b100_0000_0000));
        @(posedge clk); #1;
        reset    = 1'b0;
        wr_valid = 1'b0;
        repeat (6) @(negedge clk);

        // Master recovers cleanly after the abandoned burst
        run_vec(vecs[1]);

        check("done_pulse_count", 64'(done_cnt), 64'(NVEC + 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
